cpu_power_supervisor: RTL and testbench

- Supervisory FSM that drives the `enable` input of the Exynos CPU power sequencer.
- Enforces a power-on settle delay and a minimum off-time between power cycles.
- Watches CPU boot completion and a CPU heartbeat; on boot timeout or heartbeat loss it power-cycles the CPU, with bounded retries, then latches a fault.
- Sits in the CPLD between board-level enable logic and the sequencer.

---
 rtl/cpu_power_supervisor_if.sv | 29 ++
 rtl/cpu_power_supervisor.sv | 136 +++++++++++++
 tb/tb_cpu_power_supervisor.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_power_supervisor_if.sv
// cpu_power_supervisor_if: board-side signal bundle of the CPU power supervisor.
//   master: board/CPU side; drives the requests and CPU status, observes the supervisor outputs.
//   slave : supervisor side; the mirror image.
//   board_enable_req  request CPU powered (level, sysclk-synchronous)
//   reboot_req        graceful power-cycle request (single-cycle pulse)
//   cpu_boot_done     CPU OS-up level (asynchronous)
//   cpu_heartbeat     CPU alive toggle (asynchronous)
//   cpu_seq_enable    enable to the power sequencer
//   fault             retries exhausted
//   retry_count       automatic retries consumed
//   sup_state         current supervisor state (debug)
interface cpu_power_supervisor_if;
    logic       board_enable_req;
    logic       reboot_req;
    logic       cpu_boot_done;
    logic       cpu_heartbeat;
    logic       cpu_seq_enable;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] sup_state;
    modport master (
        output board_enable_req, reboot_req, cpu_boot_done, cpu_heartbeat,
        input  cpu_seq_enable, fault, retry_count, sup_state
    );
    modport slave (
        input  board_enable_req, reboot_req, cpu_boot_done, cpu_heartbeat,
        output cpu_seq_enable, fault, retry_count, sup_state
    );
endinterface

// File: rtl/cpu_power_supervisor.sv
// cpu_power_supervisor: supervisory FSM driving the CPU power sequencer enable.
//   sysclk  system clock
//   reset   asynchronous active-high reset
//   bus     cpu_power_supervisor_if.slave (requests, CPU status in; enable, fault, retry_count, sup_state out)
// Enforces a settle delay after reset and a minimum off-time between power cycles,
// power-cycles the CPU on boot timeout or heartbeat loss, and latches a fault once
// the retry budget is spent.
module cpu_power_supervisor #(
    parameter int TICK_DIV                = 500,
    parameter int SETTLE_TICKS            = 100,
    parameter int BOOT_TIMEOUT_TICKS      = 20000,
    parameter int HEARTBEAT_TIMEOUT_TICKS = 5000,
    parameter int OFF_HOLD_TICKS          = 200,
    parameter int MAX_RETRIES             = 3
) (
    input logic             sysclk,
    input logic             reset,
    cpu_power_supervisor_if.slave bus
);
    localparam int M1   = SETTLE_TICKS > OFF_HOLD_TICKS ? SETTLE_TICKS : OFF_HOLD_TICKS;
    localparam int M2   = BOOT_TIMEOUT_TICKS > HEARTBEAT_TIMEOUT_TICKS ? BOOT_TIMEOUT_TICKS : HEARTBEAT_TIMEOUT_TICKS;
    localparam int TMAX = M1 > M2 ? M1 : M2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_TICKS);
    localparam logic [TW-1:0] T_BOOT   = TW'(BOOT_TIMEOUT_TICKS);
    localparam logic [TW-1:0] T_HB     = TW'(HEARTBEAT_TIMEOUT_TICKS);
    localparam logic [TW-1:0] T_OFF    = TW'(OFF_HOLD_TICKS);

    typedef enum logic [2:0] {
        SETTLE   = 3'd0,
        IDLE     = 3'd1,
        BOOTING  = 3'd2,
        RUNNING  = 3'd3,
        COOLDOWN = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t        state, nxt;
    logic [PW-1:0] presc;
    logic [TW-1:0] timer;
    logic [1:0]    retry;
    logic [1:0]    retry_inc;
    logic          bd_s1, bd_s2, hb_s1, hb_s2, hb_d;
    logic          cause_fail;
    logic          fail;
    logic          tick;
    logic          hb_edge;
    logic          ben;

    assign ben       = bus.board_enable_req;
    assign tick      = presc == P_LAST;
    assign hb_edge   = hb_s2 ^ hb_d;
    assign retry_inc = retry == 2'd3 ? retry : retry + 2'd1;
    assign bus.sup_state   = state;
    assign bus.retry_count = retry;

    // Free-running time base and CPU-side synchronisers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            bd_s1 <= 1'b0;
            bd_s2 <= 1'b0;
            hb_s1 <= 1'b0;
            hb_s2 <= 1'b0;
            hb_d  <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            bd_s1 <= bus.cpu_boot_done;
            bd_s2 <= bd_s1;
            hb_s1 <= bus.cpu_heartbeat;
            hb_s2 <= hb_s1;
            hb_d  <= hb_s2;
        end
    end

    // fail marks a COOLDOWN entry caused by boot timeout or heartbeat loss.
    always_comb begin
        nxt  = state;
        fail = 1'b0;
        case (state)
            SETTLE:   if (timer == T_SETTLE) nxt = IDLE;
            IDLE:     if (ben) nxt = BOOTING;
            BOOTING: begin
                if (!ben) nxt = COOLDOWN;
                else if (bd_s2) nxt = RUNNING;
                else if (timer == T_BOOT) begin
                    nxt  = COOLDOWN;
                    fail = 1'b1;
                end
            end
            RUNNING: begin
                if (!ben || bus.reboot_req) nxt = COOLDOWN;
                else if (timer == T_HB && !hb_edge) begin
                    nxt  = COOLDOWN;
                    fail = 1'b1;
                end
            end
            COOLDOWN: begin
                // retry was already incremented on the failure entry
                if (timer == T_OFF)
                    nxt = !ben ? IDLE : (cause_fail && int'(retry) > MAX_RETRIES - 1) ? FAULT : BOOTING;
            end
            FAULT:    if (!ben) nxt = IDLE;
            default:  nxt = SETTLE;
        endcase
    end

    // Outputs are registered from the next state so they move with the state register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state              <= SETTLE;
            timer              <= '0;
            retry              <= 2'd0;
            cause_fail         <= 1'b0;
            bus.cpu_seq_enable <= 1'b0;
            bus.fault          <= 1'b0;
        end else begin
            state              <= nxt;
            bus.cpu_seq_enable <= nxt == BOOTING || nxt == RUNNING;
            bus.fault          <= nxt == FAULT;
            // transition clear wins over a coincident tick
            if (nxt != state || (state == RUNNING && hb_edge))
                timer <= '0;
            else if (tick && timer != '1)
                timer <= timer + TW'(1);
            if (nxt == COOLDOWN && state != COOLDOWN)
                cause_fail <= fail;
            if ((nxt == IDLE && state != IDLE) || (state == FAULT && nxt != FAULT) || (state == RUNNING && hb_edge))
                retry <= 2'd0;
            else if (fail)
                retry <= retry_inc;
        end
    end
endmodule

// File: tb/tb_cpu_power_supervisor.sv
// tb_cpu_power_supervisor: directed self-checking bench for cpu_power_supervisor.
// Time base is 4 clocks per tick; cyc counts clock edges since reset release, so the
// prescaler phase is cyc%4 and tick edges are those with cyc%4==0.
module tb_cpu_power_supervisor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   x, k;

    cpu_power_supervisor_if bus ();

    cpu_power_supervisor #(
        .TICK_DIV(4),
        .SETTLE_TICKS(5),
        .BOOT_TIMEOUT_TICKS(10),
        .HEARTBEAT_TIMEOUT_TICKS(6),
        .OFF_HOLD_TICKS(3),
        .MAX_RETRIES(2)
    ) dut (
        .sysclk(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edge at which a state whose timer was cleared at edge c leaves after t ticks.
    function automatic int tdone(input int c, input int t);
        return c + (4 - c % 4) + 4 * (t - 1) + 1;
    endfunction

    task automatic wait_state(input logic [2:0] s, input int bound);
        int n;
        n = 0;
        while (bus.sup_state !== s && n < bound) begin
            step(1);
            n++;
        end
    endtask

    task automatic toggle_hb();
        bus.cpu_heartbeat = ~bus.cpu_heartbeat;
    endtask

    task automatic pulse_reboot();
        bus.reboot_req = 1'b1;
        step(1);
        bus.reboot_req = 1'b0;
    endtask

    initial begin
        bus.board_enable_req = 1'b1;
        bus.reboot_req       = 1'b0;
        bus.cpu_boot_done    = 1'b0;
        bus.cpu_heartbeat    = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_state", bus.sup_state, 0);
        chk("rst_en", bus.cpu_seq_enable, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_retry", bus.retry_count, 0);
        // settle: 5 ticks = 20 edges, then one IDLE cycle
        step(20);
        chk("settle_hold", bus.sup_state, 0);
        step(1);
        chk("idle_state", bus.sup_state, 1);
        chk("idle_en", bus.cpu_seq_enable, 0);
        step(1);
        chk("boot_state", bus.sup_state, 2);
        chk("boot_en", bus.cpu_seq_enable, 1);
        // boot_done at tick 4 of BOOTING, 2-FF latency
        step(14);
        bus.cpu_boot_done = 1'b1;
        step(2);
        chk("bootdone_sync", bus.sup_state, 2);
        step(1);
        chk("run_state", bus.sup_state, 3);
        chk("run_en", bus.cpu_seq_enable, 1);
        // 100 ticks of heartbeat every 4 ticks
        for (int i = 0; i < 25; i++) begin
            toggle_hb();
            step(16);
            chk("run_hold", bus.sup_state, 3);
        end
        chk("run_retry", bus.retry_count, 0);
        // heartbeat edge landing on the timeout cycle
        toggle_hb();
        x = cyc + 3;
        k = tdone(x, 6) - 1;
        while (cyc < k - 2) step(1);
        toggle_hb();
        while (cyc < k + 1) step(1);
        chk("hb_race_state", bus.sup_state, 3);
        chk("hb_race_en", bus.cpu_seq_enable, 1);
        // heartbeat stopped
        x = k + 1;
        wait_state(3'd4, 40);
        chk("hbloss_state", bus.sup_state, 4);
        chk("hbloss_time", cyc, tdone(x, 6));
        chk("hbloss_retry", bus.retry_count, 1);
        chk("hbloss_en", bus.cpu_seq_enable, 0);
        x = cyc;
        wait_state(3'd2, 20);
        chk("cool1_state", bus.sup_state, 2);
        chk("cool1_time", cyc, tdone(x, 3));
        chk("cool1_retry", bus.retry_count, 1);
        step(1);
        chk("rerun_state", bus.sup_state, 3);
        chk("rerun_retry_kept", bus.retry_count, 1);
        toggle_hb();
        step(2);
        chk("rerun_retry_pre", bus.retry_count, 1);
        step(1);
        chk("rerun_retry_clr", bus.retry_count, 0);
        // graceful reboot in RUNNING
        pulse_reboot();
        chk("reboot_state", bus.sup_state, 4);
        chk("reboot_en", bus.cpu_seq_enable, 0);
        x = cyc;
        wait_state(3'd2, 20);
        chk("reboot_time", cyc, tdone(x, 3));
        chk("reboot_en_back", bus.cpu_seq_enable, 1);
        chk("reboot_retry", bus.retry_count, 0);
        // boot never completes
        bus.cpu_boot_done = 1'b0;
        step(1);
        chk("to_run_state", bus.sup_state, 3);
        pulse_reboot();
        chk("to_cool_state", bus.sup_state, 4);
        x = cyc;
        wait_state(3'd2, 20);
        chk("to_boot_time", cyc, tdone(x, 3));
        x = cyc;
        wait_state(3'd4, 60);
        chk("bto1_state", bus.sup_state, 4);
        chk("bto1_time", cyc, tdone(x, 10));
        chk("bto1_retry", bus.retry_count, 1);
        x = cyc;
        wait_state(3'd2, 20);
        chk("bto1_reboot", cyc, tdone(x, 3));
        chk("bto1_en", bus.cpu_seq_enable, 1);
        x = cyc;
        wait_state(3'd4, 60);
        chk("bto2_time", cyc, tdone(x, 10));
        chk("bto2_retry", bus.retry_count, 2);
        x = cyc;
        wait_state(3'd5, 20);
        chk("fault_state", bus.sup_state, 5);
        chk("fault_time", cyc, tdone(x, 3));
        chk("fault_flag", bus.fault, 1);
        chk("fault_en", bus.cpu_seq_enable, 0);
        step(8);
        chk("fault_hold", bus.sup_state, 5);
        bus.board_enable_req = 1'b0;
        step(1);
        chk("fault_exit", bus.sup_state, 1);
        chk("fault_clr", bus.fault, 0);
        chk("fault_retry_clr", bus.retry_count, 0);
        // reboot_req ignored in IDLE
        pulse_reboot();
        chk("idle_reboot_state", bus.sup_state, 1);
        chk("idle_reboot_en", bus.cpu_seq_enable, 0);
        bus.board_enable_req = 1'b1;
        step(1);
        chk("reen_state", bus.sup_state, 2);
        chk("reen_retry", bus.retry_count, 0);
        // enable glitch in BOOTING never shortens the hold
        bus.board_enable_req = 1'b0;
        step(1);
        chk("glitch_state", bus.sup_state, 4);
        x = cyc;
        step(4);
        bus.board_enable_req = 1'b1;
        chk("glitch_en_low", bus.cpu_seq_enable, 0);
        wait_state(3'd2, 20);
        chk("glitch_time", cyc, tdone(x, 3));
        chk("glitch_en", bus.cpu_seq_enable, 1);
        // reset mid-operation
        rst = 1'b1;
        #1;
        chk("mid_rst_en", bus.cpu_seq_enable, 0);
        chk("mid_rst_state", bus.sup_state, 0);
        step(2);
        rst = 1'b0;
        step(21);
        chk("mid_rst_idle", bus.sup_state, 1);
        step(1);
        chk("mid_rst_boot", bus.sup_state, 2);
        chk("mid_rst_en_back", bus.cpu_seq_enable, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
